// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Multi-cycle RV32I control sequencer. It uses request/acknowledge handshakes
//   on the instruction and data buses, with a bounded wait timeout. Instructions
//   that need no memory or writeback phase skip those states. Illegal
//   instructions and bus timeouts go to a precise trap state, and a counter
//   tracks retired instructions.
//
// Parameters
//   TIMEOUT  max wait cycles for a bus ack before trapping (0 disables)
//   SKIP_WB  1: no-destination instructions bypass WB; 0: always pass WB
//   CNT_W    width of the retired-instruction counter
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   opcode, f3, f7      instruction fields from the IR (valid from DECODE on)
//   stall               freeze the sequencer
//   ibus_ack, dbus_ack  bus acknowledges
//   trap_clear          leave TRAP and refetch
//   active, alu_mode, invert_logic_result   combinational decode outputs
//   ibus_req, load_ir, dbus_req, rf_we, pc_en   sequencing strobes/requests
//   trap, trap_cause, instret                   status

package multicycle_sequencer_pkg;

  typedef enum logic [1:0] {
    DEST_REG_FROM_NONE,
    DEST_REG_FROM_ALU,
    DEST_REG_FROM_MEM,
    DEST_REG_FROM_NEXT_PC
  } dest_reg_t;

  typedef enum logic [1:0] {ALU_A_RS1, ALU_A_PC, ALU_A_ZERO} alu_a_sel_t;
  typedef enum logic {ALU_B_RS2, ALU_B_IMM} alu_b_sel_t;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_t;
  typedef enum logic [1:0] {PC_NEXT, PC_BRANCH, PC_JUMP} pc_sel_t;

  typedef struct packed {
    logic       null_cu;
    dest_reg_t  dest_reg;
    alu_a_sel_t alu_a_sel;
    alu_b_sel_t alu_b_sel;
    imm_type_t  imm_type;
    pc_sel_t    pc_sel;
    logic       dbus_we;
    logic       dbus_re;
  } ins_ctrl_signals_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_XOR, ALU_SRL,
    ALU_SRA, ALU_OR, ALU_AND, ALU_EQ, ALU_PASS_B
  } alu_op_t;

  typedef struct packed {
    alu_op_t op;
    logic    is_signed;
  } alu_mode_t;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_ALUI   = 7'h13;
  localparam logic [6:0] OP_ALU    = 7'h33;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
  localparam logic [1:0] CAUSE_IBUS    = 2'd1;
  localparam logic [1:0] CAUSE_DBUS    = 2'd2;

endpackage

// state  | meaning
// IDLE   | out of reset, start fetching next cycle
// FETCH  | ibus_req held until ibus_ack (load_ir on ack) or timeout
// DECODE | legality check of the captured instruction
// EXEC   | ALU result valid; choose MEM, WB or retire
// MEM    | dbus_req held until dbus_ack or timeout
// WB     | register file write, retire
// TRAP   | trap held with cause until trap_clear
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter bit          SKIP_WB = 1'b1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        opcode,
  input  logic [2:0]        f3,
  input  logic [6:0]        f7,
  input  logic              stall,
  input  logic              ibus_ack,
  input  logic              dbus_ack,
  input  logic              trap_clear,
  output ins_ctrl_signals_t active,
  output alu_mode_t         alu_mode,
  output logic              invert_logic_result,
  output logic              ibus_req,
  output logic              load_ir,
  output logic              dbus_req,
  output logic              rf_we,
  output logic              pc_en,
  output logic              trap,
  output logic [1:0]        trap_cause,
  output logic [CNT_W-1:0]  instret
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  // The counter never needs to hold TIMEOUT itself: the trap is taken on the
  // cycle that would bring it there.
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_t            state_q, state_n;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        cause_n;
  logic              legal;
  logic              has_dest;
  logic              wait_last;
  logic              retire;

  // ---------------------------------------------------------------- decode
  function automatic alu_mode_t alu_from_f3(input logic [2:0] fn3, input logic alt);
    alu_mode_t m;
    m.op        = ALU_ADD;
    m.is_signed = 1'b0;
    case (fn3)
      3'd0: m.op = alt ? ALU_SUB : ALU_ADD;
      3'd1: m.op = ALU_SLL;
      3'd2: begin m.op = ALU_SLT; m.is_signed = 1'b1; end
      3'd3: m.op = ALU_SLT;
      3'd4: m.op = ALU_XOR;
      3'd5: begin
        if (alt) begin m.op = ALU_SRA; m.is_signed = 1'b1; end
        else m.op = ALU_SRL;
      end
      3'd6: m.op = ALU_OR;
      default: m.op = ALU_AND;
    endcase
    return m;
  endfunction

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: legal = 1'b1;
      OP_JALR:   legal = (f3 == 3'd0);
      OP_BRANCH: legal = (f3[2:1] != 2'b01);
      OP_LOAD:   legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      OP_STORE:  legal = (f3 <= 3'd2);
      OP_ALU:    legal = (f7 == 7'h00) ||
                         (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      OP_ALUI: begin
        case (f3)
          3'd1:    legal = (f7 == 7'h00);
          3'd5:    legal = (f7 == 7'h00) || (f7 == 7'h20);
          default: legal = 1'b1;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    active              = '0;
    active.null_cu      = 1'b1;
    alu_mode.op         = ALU_ADD;
    alu_mode.is_signed  = 1'b0;
    invert_logic_result = 1'b0;
    if (legal) begin
      active.null_cu = 1'b0;
      case (opcode)
        OP_LUI: begin
          active.dest_reg  = DEST_REG_FROM_ALU;
          active.alu_a_sel = ALU_A_ZERO;
          active.alu_b_sel = ALU_B_IMM;
          active.imm_type  = IMM_U;
          alu_mode.op      = ALU_PASS_B;
        end
        OP_AUIPC: begin
          active.dest_reg  = DEST_REG_FROM_ALU;
          active.alu_a_sel = ALU_A_PC;
          active.alu_b_sel = ALU_B_IMM;
          active.imm_type  = IMM_U;
        end
        OP_JAL: begin
          // ALU forms the target; the link value is the datapath next-PC.
          active.dest_reg  = DEST_REG_FROM_NEXT_PC;
          active.alu_a_sel = ALU_A_PC;
          active.alu_b_sel = ALU_B_IMM;
          active.imm_type  = IMM_J;
          active.pc_sel    = PC_JUMP;
        end
        OP_JALR: begin
          active.dest_reg  = DEST_REG_FROM_NEXT_PC;
          active.alu_b_sel = ALU_B_IMM;
          active.imm_type  = IMM_I;
          active.pc_sel    = PC_JUMP;
        end
        OP_BRANCH: begin
          active.imm_type = IMM_B;
          active.pc_sel   = PC_BRANCH;
          // f3[0] selects the negated form (bne/bge/bgeu).
          if (f3[2]) alu_mode.op = ALU_SLT;
          else       alu_mode.op = ALU_EQ;
          alu_mode.is_signed  = f3[2] & ~f3[1];
          invert_logic_result = f3[0];
        end
        OP_LOAD: begin
          active.dest_reg  = DEST_REG_FROM_MEM;
          active.alu_b_sel = ALU_B_IMM;
          active.imm_type  = IMM_I;
          active.dbus_re   = 1'b1;
        end
        OP_STORE: begin
          active.alu_b_sel = ALU_B_IMM;
          active.imm_type  = IMM_S;
          active.dbus_we   = 1'b1;
        end
        OP_ALUI: begin
          active.dest_reg  = DEST_REG_FROM_ALU;
          active.alu_b_sel = ALU_B_IMM;
          active.imm_type  = IMM_I;
          // Only the shift-right immediate uses f7 as an alternate selector.
          alu_mode = alu_from_f3(f3, (f3 == 3'd5) && f7[5]);
        end
        OP_ALU: begin
          active.dest_reg = DEST_REG_FROM_ALU;
          alu_mode        = alu_from_f3(f3, f7[5]);
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------- sequencer
  assign has_dest  = (active.dest_reg != DEST_REG_FROM_NONE);
  assign wait_last = (TIMEOUT != 0) && (32'(wait_cnt) == TIMEOUT - 1);
  assign trap      = (state_q == S_TRAP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_n;
  end

  always_comb begin
    state_n  = state_q;
    cause_n  = trap_cause;
    load_ir  = 1'b0;
    rf_we    = 1'b0;
    pc_en    = 1'b0;
    retire   = 1'b0;
    // Requests follow the state only, so a stall leaves them at their level.
    ibus_req = (state_q == S_FETCH);
    dbus_req = (state_q == S_MEM);
    if (!stall) begin
      case (state_q)
        S_IDLE: state_n = S_FETCH;
        S_FETCH: begin
          if (ibus_ack) begin
            load_ir = 1'b1;
            state_n = S_DECODE;
          end else if (wait_last) begin
            state_n = S_TRAP;
            cause_n = CAUSE_IBUS;
          end
        end
        S_DECODE: begin
          if (active.null_cu) begin
            state_n = S_TRAP;
            cause_n = CAUSE_ILLEGAL;
          end else begin
            state_n = S_EXEC;
          end
        end
        S_EXEC: begin
          if (active.dbus_re || active.dbus_we) state_n = S_MEM;
          else if (has_dest || !SKIP_WB)        state_n = S_WB;
          else                                  retire  = 1'b1;
        end
        S_MEM: begin
          if (dbus_ack) begin
            if (active.dbus_re) state_n = S_WB;
            else                retire  = 1'b1;
          end else if (wait_last) begin
            state_n = S_TRAP;
            cause_n = CAUSE_DBUS;
          end
        end
        S_WB: begin
          rf_we  = has_dest;
          retire = 1'b1;
        end
        S_TRAP: if (trap_clear) state_n = S_FETCH;
        default: state_n = S_IDLE;
      endcase
      if (retire) begin
        state_n = S_FETCH;
        pc_en   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt   <= '0;
      trap_cause <= CAUSE_ILLEGAL;
      instret    <= '0;
    end else begin
      trap_cause <= cause_n;
      if (pc_en) instret <= instret + CNT_W'(1);
      if (!stall) begin
        if (state_n == state_q && (state_q == S_FETCH || state_q == S_MEM))
          wait_cnt <= wait_cnt + WAIT_W'(1);
        else
          wait_cnt <= '0;
      end
    end
  end

endmodule
